// File: rtl/draw_frame_scheduler_if.sv
// Pixel-port sharing bundle: drawer requests and pixel streams in, grants and the
// adapter-side pixel stream plus frame status out.
interface draw_frame_scheduler_if #(
   parameter int N_REQ = 4
);
   logic               tick;
   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   done;
   logic [8*N_REQ-1:0] px_x;
   logic [7*N_REQ-1:0] px_y;
   logic [3*N_REQ-1:0] px_col;
   logic [N_REQ-1:0]   px_plot;
   logic [N_REQ-1:0]   gnt;
   logic [7:0]         x;
   logic [6:0]         y;
   logic [2:0]         colour;
   logic               plot;
   logic               busy;
   logic               frame_done;
   logic [7:0]         overrun_cnt;
   logic               timeout_err;

   modport master (
      output tick, req, done, px_x, px_y, px_col, px_plot,
      input  gnt, x, y, colour, plot, busy, frame_done, overrun_cnt, timeout_err
   );

   modport slave (
      input  tick, req, done, px_x, px_y, px_col, px_plot,
      output gnt, x, y, colour, plot, busy, frame_done, overrun_cnt, timeout_err
   );
endinterface

// File: rtl/draw_frame_scheduler.sv
// Per-frame scheduler: snapshots drawer requests on tick and grants the single VGA
// pixel port to each requester in ascending order, with a per-grant timeout.
module draw_frame_scheduler #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 1023,
   parameter int TO_W    = 10
) (
   input  logic                  Clock,
   input  logic                  Areset,
   draw_frame_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SELECT, ACTIVE, FINISH} state_t;

   state_t           state_reg, state_next;
   logic [N_REQ-1:0] pending_reg, pending_next;
   logic [N_REQ-1:0] gnt_reg, gnt_next;
   logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
   logic             empty_done_reg, empty_done_next;
   logic             timeout_err_reg, timeout_set;
   logic [7:0]       overrun_reg;
   logic [N_REQ-1:0] lowest;
   logic             done_hit, timed_out;

   logic [7:0]       x_reg, x_sel;
   logic [6:0]       y_reg, y_sel;
   logic [2:0]       colour_reg, colour_sel;
   logic             plot_reg;
   logic [7:0]       x_m [N_REQ];
   logic [6:0]       y_m [N_REQ];
   logic [2:0]       c_m [N_REQ];

   // Lowest set pending bit as a one-hot mask (highest index scanned first, lowest wins).
   always_comb begin
      lowest = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (pending_reg[i]) begin
            lowest    = '0;
            lowest[i] = 1'b1;
         end
      end
   end

   assign done_hit  = |(bus.done & gnt_reg);
   assign timed_out = (to_cnt_reg == TO_W'(TIMEOUT));

   always_comb begin
      state_next      = state_reg;
      pending_next    = pending_reg;
      gnt_next        = gnt_reg;
      to_cnt_next     = to_cnt_reg;
      empty_done_next = 1'b0;
      timeout_set     = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (bus.tick) begin
               pending_next = bus.req;
               if (bus.req != '0) state_next = SELECT;
               else               empty_done_next = 1'b1;
            end
         end
         SELECT: begin
            gnt_next     = lowest;
            pending_next = pending_reg & ~lowest;
            to_cnt_next  = '0;
            state_next   = ACTIVE;
         end
         ACTIVE: begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
            if (done_hit || timed_out) begin
               gnt_next    = '0;
               timeout_set = !done_hit;
               state_next  = (pending_reg != '0) ? SELECT : FINISH;
            end
         end
         FINISH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Grant is one-hot, so masking each drawer and OR-ing the results forms the mux.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mux
      assign x_m[gi] = gnt_reg[gi] ? bus.px_x[8*gi +: 8]   : 8'd0;
      assign y_m[gi] = gnt_reg[gi] ? bus.px_y[7*gi +: 7]   : 7'd0;
      assign c_m[gi] = gnt_reg[gi] ? bus.px_col[3*gi +: 3] : 3'd0;
   end

   always_comb begin
      x_sel      = '0;
      y_sel      = '0;
      colour_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         x_sel      = x_sel | x_m[i];
         y_sel      = y_sel | y_m[i];
         colour_sel = colour_sel | c_m[i];
      end
   end

   always_ff @(posedge Clock) begin
      if (!Areset) begin
         state_reg       <= IDLE;
         pending_reg     <= '0;
         gnt_reg         <= '0;
         to_cnt_reg      <= '0;
         empty_done_reg  <= 1'b0;
         timeout_err_reg <= 1'b0;
         overrun_reg     <= 8'd0;
         x_reg           <= 8'd0;
         y_reg           <= 7'd0;
         colour_reg      <= 3'd0;
         plot_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pending_reg    <= pending_next;
         gnt_reg        <= gnt_next;
         to_cnt_reg     <= to_cnt_next;
         empty_done_reg <= empty_done_next;
         if (timeout_set) timeout_err_reg <= 1'b1;
         if (bus.tick && state_reg != IDLE && overrun_reg != 8'hFF)
            overrun_reg <= overrun_reg + 8'd1;
         x_reg      <= x_sel;
         y_reg      <= y_sel;
         colour_reg <= colour_sel;
         plot_reg   <= |(bus.px_plot & gnt_reg);
      end
   end

   assign bus.gnt         = gnt_reg;
   assign bus.x           = x_reg;
   assign bus.y           = y_reg;
   assign bus.colour      = colour_reg;
   assign bus.plot        = plot_reg;
   assign bus.busy        = (state_reg != IDLE) | empty_done_reg;
   assign bus.frame_done  = (state_reg == FINISH) | empty_done_reg;
   assign bus.overrun_cnt = overrun_reg;
   assign bus.timeout_err = timeout_err_reg;
endmodule
